// File: rtl/riscv_v_dispatch.sv
// riscv_v_dispatch
// Scalar-core side of the scalar<->vector link.
//  - Takes decoded vector instructions from scalar ID and registers them into the
//    vector unit's ID stage (NOP fills every slot that carries no new instruction).
//  - Back-pressures scalar ID on vector stall, scalar stall, a full pending FIFO,
//    or a CSR write that must wait for outstanding scalar writebacks (DRAIN).
//  - Keeps a FIFO of scalar rd indices still owed a result by the vector unit and
//    steers each returned value into the scalar integer RF in the same cycle.
// Ports
//  clk, rst                  clock, synchronous active-high reset
//  i_id_*                    instruction, operands and CSR write from scalar ID
//  o_id_ready                instruction accepted this cycle
//  i_core_stall, i_flush     scalar stall, squash of all in-flight vector work
//  o_v_*                     system-side signals towards the vector unit
//  i_v_riscv_v_stall         vector unit stall
//  i_v_int_rf_wr_en_wb/data  scalar result returned by the vector unit
//  o_int_wb_en/rd/data       scalar RF write port
//  o_sb_busy                 per-rd pending-writeback scoreboard (bit 0 always 0)
module riscv_v_dispatch #(
    parameter int XLEN       = 32,
    parameter int OPC_W      = 8,
    parameter int PEND_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_id_valid,
    output logic             o_id_ready,
    input  logic [31:0]      i_id_instruction,
    input  logic [OPC_W-1:0] i_id_opcode,
    input  logic [XLEN-1:0]  i_id_rs1_data,
    input  logic [4:0]       i_id_rd,
    input  logic             i_id_wr_scalar,
    input  logic [5:0]       i_id_csr_wr,
    input  logic [XLEN-1:0]  i_id_csr_data,
    input  logic             i_core_stall,
    input  logic             i_flush,
    output logic             o_v_rst,
    output logic             o_v_clear_pipe,
    output logic             o_v_riscv_stall,
    input  logic             i_v_riscv_v_stall,
    output logic [31:0]      o_v_instruction_id,
    output logic [OPC_W-1:0] o_v_opcode_id,
    output logic [XLEN-1:0]  o_v_int_rf_rd_data_id,
    output logic [5:0]       o_v_ext_wr_id,
    output logic [XLEN-1:0]  o_v_ext_data_in_exe,
    input  logic             i_v_int_rf_wr_en_wb,
    input  logic [XLEN-1:0]  i_v_int_rf_wr_data_wb,
    output logic             o_int_wb_en,
    output logic [4:0]       o_int_wb_rd,
    output logic [XLEN-1:0]  o_int_wb_data,
    output logic [31:0]      o_sb_busy
);

    localparam int          AW  = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSH} state_e;

    state_e          r_state, w_state_next;
    logic            r_rst_q;
    logic [4:0]      r_fifo_mem [PEND_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_instr;
    logic [OPC_W-1:0] r_opc;
    logic [XLEN-1:0] r_rs1;
    logic [5:0]      r_ext_wr;
    logic [XLEN-1:0] r_csr_data;
    logic [XLEN-1:0] r_ext_data;

    logic            w_fifo_empty, w_fifo_full, w_csr_any;
    logic            w_accept, w_push, w_pop;
    logic [4:0]      w_head_rd;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CW'(PEND_DEPTH));
    assign w_csr_any    = |i_id_csr_wr;
    assign w_head_rd    = r_fifo_mem[r_rd_ptr];

    // Flush and reset also block acceptance so no instruction is taken and then lost.
    assign o_id_ready = ~rst & ~i_flush & (r_state == ST_RUN) & ~i_v_riscv_v_stall
                      & ~i_core_stall & ~(i_id_wr_scalar & w_fifo_full)
                      & ~(w_csr_any & ~w_fifo_empty);

    assign w_accept = i_id_valid & o_id_ready;
    assign w_push   = w_accept & i_id_wr_scalar & (i_id_rd != 5'd0);
    // Returns arriving in FLUSH belong to squashed work and are dropped.
    assign w_pop    = i_v_int_rf_wr_en_wb & ~rst & (r_state != ST_FLUSH) & ~w_fifo_empty;

    assign o_int_wb_en   = w_pop;
    assign o_int_wb_rd   = w_pop ? w_head_rd : 5'd0;
    assign o_int_wb_data = w_pop ? i_v_int_rf_wr_data_wb : '0;

    assign o_v_rst               = rst | r_rst_q;
    assign o_v_clear_pipe        = (r_state == ST_FLUSH);
    assign o_v_riscv_stall       = i_core_stall;
    assign o_v_instruction_id    = r_instr;
    assign o_v_opcode_id         = r_opc;
    assign o_v_int_rf_rd_data_id = r_rs1;
    assign o_v_ext_wr_id         = r_ext_wr;
    assign o_v_ext_data_in_exe   = r_ext_data;

    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = ST_FLUSH;
        end else begin
            unique case (r_state)
                ST_RUN:   if (i_id_valid && w_csr_any && !w_fifo_empty) w_state_next = ST_DRAIN;
                ST_DRAIN: if (w_fifo_empty) w_state_next = ST_RUN;
                ST_FLUSH: w_state_next = ST_RUN;
                default:  w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_next;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= i_id_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= '0;
            r_opc      <= '0;
            r_rs1      <= '0;
            r_ext_wr   <= '0;
            r_csr_data <= '0;
            r_ext_data <= '0;
        end else begin
            if (i_flush) begin
                r_instr  <= NOP;
                r_opc    <= '0;
                r_rs1    <= '0;
                r_ext_wr <= '0;
            end else if (w_accept) begin
                r_instr  <= i_id_instruction;
                r_opc    <= i_id_opcode;
                r_rs1    <= i_id_rs1_data;
                r_ext_wr <= i_id_csr_wr;
                if (w_csr_any) r_csr_data <= i_id_csr_data;
            end else if (i_v_riscv_v_stall) begin
                // Hold the instruction slot, but the CSR strobe is a single pulse.
                r_ext_wr <= '0;
            end else begin
                r_instr  <= NOP;
                r_opc    <= '0;
                r_rs1    <= '0;
                r_ext_wr <= '0;
            end
            // CSR data trails its strobe by one cycle and then holds.
            if (|r_ext_wr) r_ext_data <= r_csr_data;
        end
    end

    // Per-rd counters so two in-flight writes to the same rd keep the bit set
    // until the last one returns.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign o_sb_busy[gi] = 1'b0;
            end else begin : g_cnt
                logic [CW-1:0] r_cnt;
                logic          w_inc, w_dec;
                assign w_inc = w_push && (i_id_rd == 5'(gi));
                assign w_dec = w_pop && (w_head_rd == 5'(gi));
                always_ff @(posedge clk) begin
                    if (rst || i_flush) r_cnt <= '0;
                    else                r_cnt <= r_cnt + CW'(w_inc) - CW'(w_dec);
                end
                assign o_sb_busy[gi] = (r_cnt != '0);
            end
        end
    endgenerate

    // A return with nothing pending is a protocol error from the vector unit.
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        (i_v_int_rf_wr_en_wb && (r_state != ST_FLUSH)) |-> !w_fifo_empty);

endmodule
